// File: rtl/sd_trace_capture.sv
// Debug trace capture buffer: records the controller's 8-bit trace stream into a
// circular buffer, freezes it after a pattern/mask trigger, and lets software drain it.
module sd_trace_capture #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              PCLK_i,
  input  logic              PRESETn_i,
  input  logic [7:0]        trace_data_i,
  input  logic              trace_valid_i,
  input  logic              cap_enable_i,
  input  logic              clear_i,
  input  logic [7:0]        trig_value_i,
  input  logic [7:0]        trig_mask_i,
  input  logic [ADDR_W:0]   post_count_i,
  input  logic              rd_req_i,
  output logic [7:0]        rd_data_o,
  output logic              rd_valid_o,
  output logic [1:0]        state_o,
  output logic [ADDR_W:0]   count_o,
  output logic              triggered_o,
  output logic              wrapped_o,
  output logic              err_seen_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   rptr_q, rptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     post_q, post_d;
  logic                triggered_q, triggered_d;
  logic                wrapped_q, wrapped_d;
  logic                err_q, err_d;
  logic [7:0]          rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                wr_en;
  logic                match;

  logic [7:0] mem [DEPTH];

  assign match = trace_valid_i &&
                 ((trace_data_i & trig_mask_i) == (trig_value_i & trig_mask_i));

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    post_d      = post_q;
    triggered_d = triggered_q;
    wrapped_d   = wrapped_q;
    err_d       = err_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    wr_en       = 1'b0;

    if (clear_i) begin
      state_d     = IDLE;
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      post_d      = '0;
      triggered_d = 1'b0;
      wrapped_d   = 1'b0;
      err_d       = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cap_enable_i) begin
            state_d     = ARMED;
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            triggered_d = 1'b0;
            wrapped_d   = 1'b0;
            err_d       = 1'b0;
          end
        end
        ARMED, POST: begin
          if (trace_valid_i) begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + PTR_ONE;
            // A full buffer drops its oldest byte so the window always ends at the newest.
            if (count_q == FULL_CNT) begin
              rptr_d    = rptr_q + PTR_ONE;
              wrapped_d = 1'b1;
            end else begin
              count_d = count_q + CNT_ONE;
            end
            if (trace_data_i == 8'hFF) err_d = 1'b1;
            if (state_q == ARMED) begin
              if (match) begin
                triggered_d = 1'b1;
                post_d      = post_count_i;
                state_d     = (post_count_i == '0) ? DONE : POST;
              end
            end else begin
              post_d = post_q - CNT_ONE;
              if (post_q == CNT_ONE) state_d = DONE;
            end
          end
          if (!cap_enable_i) state_d = DONE;
        end
        DONE: begin
          if (rd_req_i && count_q != '0) begin
            rd_data_d  = mem[rptr_q];
            rd_valid_d = 1'b1;
            rptr_d     = rptr_q + PTR_ONE;
            count_d    = count_q - CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      post_q      <= '0;
      triggered_q <= 1'b0;
      wrapped_q   <= 1'b0;
      err_q       <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      post_q      <= post_d;
      triggered_q <= triggered_d;
      wrapped_q   <= wrapped_d;
      err_q       <= err_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // NOTE: the buffer array has no reset; its contents are only read behind count_q.
  always_ff @(posedge PCLK_i) begin
    if (wr_en) mem[wptr_q] <= trace_data_i;
  end

  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign state_o     = state_q;
  assign count_o     = count_q;
  assign triggered_o = triggered_q;
  assign wrapped_o   = wrapped_q;
  assign err_seen_o  = err_q;

endmodule

// File: tb/tb_sd_trace_capture.sv
// Directed self-checking bench for sd_trace_capture (DEPTH = 64).
module tb_sd_trace_capture;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              PCLK_i = 1'b0;
  logic              PRESETn_i;
  logic [7:0]        trace_data_i;
  logic              trace_valid_i;
  logic              cap_enable_i;
  logic              clear_i;
  logic [7:0]        trig_value_i;
  logic [7:0]        trig_mask_i;
  logic [ADDR_W:0]   post_count_i;
  logic              rd_req_i;
  logic [7:0]        rd_data_o;
  logic              rd_valid_o;
  logic [1:0]        state_o;
  logic [ADDR_W:0]   count_o;
  logic              triggered_o;
  logic              wrapped_o;
  logic              err_seen_o;

  int n_checks = 0;
  int n_errors = 0;

  sd_trace_capture #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .PCLK_i        (PCLK_i),
    .PRESETn_i     (PRESETn_i),
    .trace_data_i  (trace_data_i),
    .trace_valid_i (trace_valid_i),
    .cap_enable_i  (cap_enable_i),
    .clear_i       (clear_i),
    .trig_value_i  (trig_value_i),
    .trig_mask_i   (trig_mask_i),
    .post_count_i  (post_count_i),
    .rd_req_i      (rd_req_i),
    .rd_data_o     (rd_data_o),
    .rd_valid_o    (rd_valid_o),
    .state_o       (state_o),
    .count_o       (count_o),
    .triggered_o   (triggered_o),
    .wrapped_o     (wrapped_o),
    .err_seen_o    (err_seen_o)
  );

  always #5 PCLK_i = ~PCLK_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge PCLK_i);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    trace_data_i  = b;
    trace_valid_i = 1'b1;
    tick();
    trace_valid_i = 1'b0;
  endtask

  task automatic read_byte(output logic [7:0] d, output logic v);
    rd_req_i = 1'b1;
    tick();
    rd_req_i = 1'b0;
    d = rd_data_o;
    v = rd_valid_o;
  endtask

  task automatic do_clear();
    cap_enable_i = 1'b0;
    clear_i      = 1'b1;
    tick();
    clear_i      = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_state"}, 32'(state_o), 32'd0);
    check({tag, "_count"}, 32'(count_o), 32'd0);
    check({tag, "_flags"}, {29'd0, triggered_o, wrapped_o, err_seen_o}, 32'd0);
  endtask

  logic [7:0] rd;
  logic       rv;
  logic [7:0] t1_exp [6] = '{8'h10, 8'h11, 8'h5A, 8'h20, 8'h21, 8'h22};

  initial begin
    PRESETn_i     = 1'b0;
    trace_data_i  = '0;
    trace_valid_i = 1'b0;
    cap_enable_i  = 1'b0;
    clear_i       = 1'b0;
    trig_value_i  = '0;
    trig_mask_i   = '0;
    post_count_i  = '0;
    rd_req_i      = 1'b0;

    // Reset state
    #12;
    check_cleared("reset");
    check("reset_rd", {23'd0, rd_valid_o, rd_data_o}, 32'd0);
    PRESETn_i = 1'b1;
    tick();

    // 1: exact-match trigger with three post-trigger bytes
    trig_mask_i  = 8'hFF;
    trig_value_i = 8'h5A;
    post_count_i = 7'd3;
    cap_enable_i = 1'b1;
    tick();
    check("t1_armed", 32'(state_o), 32'd1);
    send(8'h10);
    send(8'h11);
    send(8'h5A);
    check("t1_post", 32'(state_o), 32'd2);
    check("t1_trig", 32'(triggered_o), 32'd1);
    send(8'h20);
    send(8'h21);
    send(8'h22);
    check("t1_done", 32'(state_o), 32'd3);
    send(8'h23);
    check("t1_count", 32'(count_o), 32'd6);
    check("t1_wrap", 32'(wrapped_o), 32'd0);
    for (int i = 0; i < 6; i++) begin
      read_byte(rd, rv);
      check($sformatf("t1_rd%0d", i), {23'd0, rv, rd}, {23'd0, 1'b1, t1_exp[i]});
    end
    check("t1_empty", 32'(count_o), 32'd0);
    tick();
    check("t1_rdv_pulse", 32'(rd_valid_o), 32'd0);
    do_clear();

    // 2: no trigger, 70 bytes overflow a 64-byte buffer
    trig_value_i = 8'hAA;
    cap_enable_i = 1'b1;
    tick();
    for (int i = 0; i < 70; i++) send(8'(i));
    cap_enable_i = 1'b0;
    tick();
    check("t2_done", 32'(state_o), 32'd3);
    check("t2_count", 32'(count_o), 32'd64);
    check("t2_wrap", 32'(wrapped_o), 32'd1);
    check("t2_trig", 32'(triggered_o), 32'd0);
    for (int i = 0; i < 64; i++) begin
      read_byte(rd, rv);
      check($sformatf("t2_rd%0d", i), {23'd0, rv, rd}, {23'd0, 1'b1, 8'(i + 6)});
    end
    check("t2_empty", 32'(count_o), 32'd0);
    do_clear();

    // 3: zero mask, zero post count
    trig_mask_i  = 8'h00;
    post_count_i = 7'd0;
    cap_enable_i = 1'b1;
    tick();
    send(8'h33);
    check("t3_done", 32'(state_o), 32'd3);
    check("t3_trig", 32'(triggered_o), 32'd1);
    check("t3_count", 32'(count_o), 32'd1);
    read_byte(rd, rv);
    check("t3_rd", {23'd0, rv, rd}, {23'd0, 1'b1, 8'h33});
    do_clear();

    // 4: error marker before trigger, abort with a byte in the same cycle
    trig_mask_i  = 8'hFF;
    trig_value_i = 8'h5A;
    post_count_i = 7'd4;
    cap_enable_i = 1'b1;
    tick();
    send(8'h01);
    send(8'hFF);
    check("t4_err", 32'(err_seen_o), 32'd1);
    send(8'h02);
    send(8'h5A);
    send(8'h03);
    cap_enable_i = 1'b0;
    send(8'h04);
    check("t4_done", 32'(state_o), 32'd3);
    check("t4_count", 32'(count_o), 32'd6);
    tick();
    check("t4_err_held", 32'(err_seen_o), 32'd1);
    do_clear();
    check_cleared("t4_clr");

    // 5: reads ignored outside DONE, on empty, and under clear
    post_count_i = 7'd2;
    cap_enable_i = 1'b1;
    tick();
    send(8'h07);
    send(8'h08);
    read_byte(rd, rv);
    check("t5_armed_rdv", 32'(rv), 32'd0);
    check("t5_armed_cnt", 32'(count_o), 32'd2);
    cap_enable_i = 1'b0;
    tick();
    read_byte(rd, rv);
    check("t5_rd", {23'd0, rv, rd}, {23'd0, 1'b1, 8'h07});
    rd_req_i = 1'b1;
    clear_i  = 1'b1;
    tick();
    rd_req_i = 1'b0;
    clear_i  = 1'b0;
    check("t5_clr_rdv", 32'(rd_valid_o), 32'd0);
    check("t5_clr_state", 32'(state_o), 32'd0);
    cap_enable_i = 1'b1;
    tick();
    cap_enable_i = 1'b0;
    tick();
    check("t5_empty_done", 32'(state_o), 32'd3);
    read_byte(rd, rv);
    check("t5_empty_rd", {23'd0, rv, rd}, {23'd0, 1'b0, 8'h07});
    check("t5_empty_cnt", 32'(count_o), 32'd0);
    do_clear();

    // 6: asynchronous reset in POST
    post_count_i = 7'd10;
    cap_enable_i = 1'b1;
    tick();
    send(8'h5A);
    send(8'h01);
    check("t6_post", 32'(state_o), 32'd2);
    cap_enable_i = 1'b0;
    #2;
    PRESETn_i = 1'b0;
    #1;
    check_cleared("t6_async");
    check("t6_rd", {23'd0, rd_valid_o, rd_data_o}, 32'd0);
    tick();
    PRESETn_i = 1'b1;
    tick();
    check("t6_after", 32'(state_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sd_trace_capture.md
Name: sd_trace_capture

Overview:
- Receive end of the SD controller debug trace port: captures the 8-bit trace byte stream (data + valid, no back-pressure) into an on-chip circular buffer.
- Pattern/mask trigger with a programmable post-trigger byte count.
- Frozen buffer is drained by software through a single-cycle read-request port.
- Lives in the PCLK_i domain next to the debug controller; its trace_data_o/trace_valid_o drive this block's trace inputs directly.

Parameters:
- DEPTH, 64, buffer depth in bytes; power of two, 4..1024.
- ADDR_W, 6, log2(DEPTH); pointer width.

Ports:
- PCLK_i  input  1  clock
- PRESETn_i  input  1  reset, asynchronous, active-low
- trace_data_i  input  8  trace byte
- trace_valid_i  input  1  trace byte valid, one byte per cycle
- cap_enable_i  input  1  level; arm capture / abort capture when dropped
- clear_i  input  1  pulse; return to IDLE, flush buffer, clear flags
- trig_value_i  input  8  trigger compare value
- trig_mask_i  input  8  trigger compare mask, 1 = bit compared
- post_count_i  input  ADDR_W+1  bytes stored after the trigger byte, 0..DEPTH
- rd_req_i  input  1  pop one byte (honoured in DONE only)
- rd_data_o  output  8  popped byte
- rd_valid_o  output  1  rd_data_o valid, one-cycle pulse
- state_o  output  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- count_o  output  ADDR_W+1  bytes held, 0..DEPTH
- triggered_o  output  1  sticky: trigger hit
- wrapped_o  output  1  sticky: oldest data overwritten
- err_seen_o  output  1  sticky: byte 8'hFF (debug error marker) captured

Behaviour:
- Reset: all outputs 0; wptr = rptr = 0; post counter 0; state IDLE. Buffer contents are don't-care.
- Match condition: trace_valid_i && ((trace_data_i & trig_mask_i) == (trig_value_i & trig_mask_i)). A mask of 0 matches the first valid byte.
- IDLE:
  - No writes.
  - cap_enable_i = 1 -> ARMED next cycle; wptr, rptr, count and sticky flags are cleared on that transition.
- ARMED:
  - Every valid byte is written at wptr; wptr++.
  - count++ if count < DEPTH. Otherwise rptr++ (overwrite oldest) and wrapped_o <= 1.
  - On a match, the matching byte is stored, triggered_o <= 1, and the post counter loads post_count_i.
  - Next state is POST, or DONE directly if post_count_i == 0.
- POST:
  - Valid bytes are stored with the same write/overwrite rules; the post counter decrements per stored byte.
  - The byte that brings the counter to 0 is stored; state -> DONE on the following cycle.
  - Further matches are ignored.
- ARMED/POST with cap_enable_i = 0: -> DONE next cycle; a byte valid in that same cycle is still stored.
- err_seen_o: set when a stored byte equals 8'hFF (ARMED/POST only).
- DONE:
  - No writes; trace input ignored.
  - rd_req_i with count > 0: next cycle rd_data_o = mem[rptr] and rd_valid_o = 1; rptr++ and count-- are registered.
  - rd_req_i with count == 0: ignored (rd_valid_o = 0, rd_data_o holds).
  - rd_data_o holds its last value between reads.
  - cap_enable_i has no effect in DONE; only clear_i leaves DONE.
- rd_req_i in IDLE/ARMED/POST: ignored.
- clear_i (any state): -> IDLE next cycle; pointers, count and sticky flags cleared; rd_valid_o forced 0. clear_i has priority over every other input in that cycle.
- Read order: oldest to newest. After a wrap, the first byte read is the oldest surviving byte.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows.
- Latency: trace byte to visible in count_o is 1 cycle; rd_req_i to rd_valid_o is 1 cycle.
- Async reset mid-capture aborts immediately; the captured data is lost.

Test Plan:
1. Reset, cap_enable_i = 1, mask 8'hFF, value 8'h5A, post_count_i = 3; send 10, 11, 5A, 20, 21, 22, 23 -> DONE after 22, count_o = 6, triggered_o = 1; six reads return 10, 11, 5A, 20, 21, 22, then count_o = 0.
2. DEPTH = 64, no match, 70 bytes 0..69 sent, then cap_enable_i = 0 -> DONE, count_o = 64, wrapped_o = 1; first read returns 6, last returns 69.
3. mask 8'h00, post_count_i = 0, first byte 8'h33 -> triggered_o = 1, DONE with count_o = 1; read returns 8'h33.
4. Stream containing 8'hFF before the trigger -> err_seen_o = 1 held through DONE; clear_i -> state_o = 0, count_o = 0, all flags 0.
5. rd_req_i asserted in ARMED and in DONE with count_o = 0 -> no rd_valid_o, count unchanged; clear_i and rd_req_i in the same DONE cycle -> no rd_valid_o, IDLE.
6. Reset asserted mid-POST -> all outputs 0 asynchronously; after release, state_o = 0.
